// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential signed divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef struct packed {
    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               trial_neg;
  } dbg_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/result bundle between the multdiv wrapper (master) and the divider (slave).
// Handshake: ctrl_DIV is a one-cycle start that samples the operands on that edge;
// data_resultRDY is a one-cycle pulse marking result/remainder/exception valid.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  dbg_t             dbg;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy, dbg
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy, dbg
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next,
  output logic             trial_neg
);

  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;

  always_comb begin
    sh        = {r, q} << 1;
    r_sh      = sh[2*WIDTH:WIDTH];
    // R stays below D, so the shifted value always fits in WIDTH+1 bits.
    trial     = r_sh - {1'b0, d};
    trial_neg = trial[WIDTH];
    r_next    = trial_neg ? r_sh : trial;
    q_next    = {sh[WIDTH-1:1], ~trial_neg};
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: sign-magnitude load, WIDTH restoring steps, sign fix-up.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  seq_divider_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic             load_en;
  logic             step_en;
  logic             fix_en;

  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             trial_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] r_low;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .r         (r),
    .q         (q),
    .d         (d),
    .r_next    (r_next),
    .q_next    (q_next),
    .trial_neg (trial_neg)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A start always wins: it restarts RUN from any state, including FIX.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.ctrl_DIV) state_next = S_RUN;
      S_RUN: begin
        if (bus.ctrl_DIV)                          state_next = S_RUN;
        else if (count == CNT_W'(WIDTH - 1))       state_next = S_FIX;
      end
      S_FIX:   state_next = bus.ctrl_DIV ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_en  = bus.ctrl_DIV;
    step_en  = (state == S_RUN) && !bus.ctrl_DIV;
    fix_en   = (state == S_FIX);
    bus.busy = (state != S_IDLE);
    bus.dbg  = '{state: state, count: count, trial_neg: trial_neg};
  end

  // Magnitudes are unsigned, so |min-int| is representable without overflow.
  always_comb begin
    a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    r_low = r[WIDTH-1:0];
    q_fix = sign_q ? -q : q;
    r_fix = sign_r ? -r_low : r_low;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count              <= '0;
      r                  <= '0;
      q                  <= '0;
      d                  <= '0;
      sign_q             <= 1'b0;
      sign_r             <= 1'b0;
      dz                 <= 1'b0;
      bus.data_result    <= '0;
      bus.data_remainder <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= fix_en;
      if (fix_en) begin
        bus.data_result    <= dz ? '0 : q_fix;
        bus.data_remainder <= dz ? '0 : r_fix;
        bus.data_exception <= dz;
      end
      if (load_en) begin
        q      <= a_mag;
        d      <= b_mag;
        r      <= '0;
        sign_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        sign_r <= bus.data_operandA[WIDTH-1];
        dz     <= (bus.data_operandB == '0);
        count  <= '0;
      end else if (step_en) begin
        r     <= r_next;
        q     <= q_next;
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule
